stream_pkt_addr_gen: RTL
========================

// Module: stream_pkt_addr_gen
// PURPOSE
//  Upstream stage of the stream-to-memory datamover. Passes an AXI-Stream packet flow through to the datamover data input and,
//  before each packet, issues the packet's destination address on the datamover address stream. Addresses walk a ring
//  buffer [cfg_base, cfg_base+cfg_size); packets are never split across the ring end. Reports per-packet byte counts and errors.
// PARAMETERS
//  DATA_WIDTH     32   stream/memory data width, bits; BYTES = DATA_WIDTH/8
//  ADDR_WIDTH     32   byte-address width
//  MAX_PKT_BEATS  256  maximum legal beats per packet; MAX_PKT_BYTES = MAX_PKT_BEATS*BYTES
// PORTS
//  clk             in   1             single clock, all logic rising-edge
//  rst             in   1             asynchronous, active-high reset
//  cfg_enable      in   1             run enable
//  cfg_base        in   ADDR_WIDTH    ring start, BYTES-aligned
//  cfg_size        in   ADDR_WIDTH    ring size in bytes, multiple of BYTES, >= MAX_PKT_BYTES
//  s_tdata         in   DATA_WIDTH    upstream stream data
//  s_tkeep         in   BYTES         upstream byte enables
//  s_tlast         in   1             upstream end of packet
//  s_tvalid        in   1             upstream valid
//  s_tready        out  1             upstream ready
//  m_tdata/m_tkeep/m_tlast out DATA_WIDTH/BYTES/1  to datamover data input (combinational copy of s_*)
//  m_tvalid        out  1             to datamover; m_tready in 1 from datamover
//  addr_tdata      out  ADDR_WIDTH    packet destination address to datamover
//  addr_tvalid     out  1             address valid; addr_tready in 1 from datamover
//  pkt_count       out  32            packets completed, wraps at 2^32
//  last_pkt_bytes  out  ADDR_WIDTH    sum of popcount(tkeep) over last completed packet
//  err_oversize    out  1             sticky: a packet exceeded MAX_PKT_BEATS
//  busy            out  1             high in any state except IDLE
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; s_tready, m_tvalid, addr_tvalid, busy, err_oversize = 0; addr_tdata, pkt_count,
//   last_pkt_bytes, wr_ptr, beat/byte counters = 0. Reset mid-packet drops the packet; restart fetches cfg_base again.
//  FSM IDLE: cfg_enable=1 -> latch base/size into internal regs, wr_ptr<=cfg_base, -> ISSUE. cfg_* changes ignored outside IDLE.
//  ISSUE: addr_tvalid=1, addr_tdata=wr_ptr (registered, stable until accepted). addr_tvalid&&addr_tready -> PASS next cycle.
//   s_tready=0 and m_tvalid=0 throughout ISSUE.
//  PASS: m_* = s_*; m_tvalid=s_tvalid; s_tready=m_tready (zero-latency pass-through, no buffering). Beat = s_tvalid&&m_tready.
//   Per beat: beats++ (saturates at MAX_PKT_BEATS), bytes += popcount(s_tkeep). Beat with s_tlast=1 -> ADVANCE.
//   Beat number MAX_PKT_BEATS accepted with s_tlast=0 -> err_oversize<=1 (sticky until reset); pass-through continues to tlast.
//  ADVANCE (exactly 1 cycle, s_tready=0): next = wr_ptr + beats*BYTES; if next + MAX_PKT_BYTES > base+size then next = base;
//   wr_ptr<=next; pkt_count++; last_pkt_bytes<=bytes; counters cleared. cfg_enable=1 -> ISSUE, else -> IDLE.
//  cfg_enable falling mid-packet: current packet completes normally, FSM returns to IDLE after ADVANCE.
//  Arithmetic in ADDR_WIDTH+1 bits for the compare; ptr never reaches base+size. Beat counter width $clog2(MAX_PKT_BEATS+1).
//  Inter-packet overhead: min 2 cycles (ADVANCE + ISSUE with addr_tready=1). Zero-tkeep beats count as beats, 0 bytes.
// TESTING (BYTES=4, MAX_PKT_BEATS=16, cfg_base=0x1000, cfg_size=0x100)
//  1 Enable, 3-beat pkt tkeep F,F,3 -> addr 0x1000 issued; last_pkt_bytes=10, pkt_count=1, next addr 0x100C.
//  2 Four 16-beat pkts -> addrs 0x1000,0x1040,0x1080,0x10C0; fifth addr wraps to 0x1000.
//  3 m_tready low 5 cycles mid-packet -> s_tready low same cycles, no beat lost/duplicated, data order intact.
//  4 addr_tready low 10 cycles -> addr_tvalid/addr_tdata stable, s_tready=0, no data passes until accepted.
//  5 20-beat pkt no early tlast -> err_oversize=1 at 16th beat, all 20 beats pass; next addr = prev+0x40 (wrap rule applied).
//  6 Assert rst during beat 2 of a packet -> all outputs at reset values same cycle; re-enable issues 0x1000, pkt_count=0.

Source files
------------

// File: rtl/stream_pkt_addr_gen.sv
// stream_pkt_addr_gen: passes an AXI-Stream packet flow to a datamover and issues each
// packet's ring-buffer destination address ahead of its data.
module stream_pkt_addr_gen #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_PKT_BEATS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_enable,
    input  logic [ADDR_WIDTH-1:0]   cfg_base,
    input  logic [ADDR_WIDTH-1:0]   cfg_size,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [ADDR_WIDTH-1:0]   addr_tdata,
    output logic                    addr_tvalid,
    input  logic                    addr_tready,
    output logic [31:0]             pkt_count,
    output logic [ADDR_WIDTH-1:0]   last_pkt_bytes,
    output logic                    err_oversize,
    output logic                    busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [ADDR_WIDTH:0] MAX_PKT_BYTES = (ADDR_WIDTH+1)'(MAX_PKT_BEATS * BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, PASS, ADVANCE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, size_q, size_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] bytes_q, bytes_d, last_bytes_q, last_bytes_d;
    logic [BW-1:0]         beats_q, beats_d;
    logic [31:0]           pkt_count_q, pkt_count_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   next_ptr, ring_end;
    logic                  beat, wrap;

    assign m_tdata        = s_tdata;
    assign m_tkeep        = s_tkeep;
    assign m_tlast        = s_tlast;
    assign m_tvalid       = (state_q == PASS) && s_tvalid;
    assign s_tready       = (state_q == PASS) && m_tready;
    assign addr_tvalid    = state_q == ISSUE;
    assign addr_tdata     = wr_ptr_q;
    assign busy           = state_q != IDLE;
    assign pkt_count      = pkt_count_q;
    assign last_pkt_bytes = last_bytes_q;
    assign err_oversize   = err_q;
    assign beat           = m_tvalid && m_tready;

    // One bit of headroom so the end-of-ring compare cannot overflow.
    assign next_ptr = {1'b0, wr_ptr_q} + (ADDR_WIDTH+1)'(beats_q) * (ADDR_WIDTH+1)'(BYTES);
    assign ring_end = {1'b0, base_q} + {1'b0, size_q};
    assign wrap     = next_ptr + MAX_PKT_BYTES > ring_end;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        size_d       = size_q;
        wr_ptr_d     = wr_ptr_q;
        bytes_d      = bytes_q;
        beats_d      = beats_q;
        last_bytes_d = last_bytes_q;
        pkt_count_d  = pkt_count_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (cfg_enable) begin
                base_d   = cfg_base;
                size_d   = cfg_size;
                wr_ptr_d = cfg_base;
                state_d  = ISSUE;
            end
            ISSUE: state_d = addr_tready ? PASS : ISSUE;
            PASS: if (beat) begin
                beats_d = (beats_q == BW'(MAX_PKT_BEATS)) ? beats_q : beats_q + 1'b1;
                bytes_d = bytes_q + ADDR_WIDTH'($countones(s_tkeep));
                err_d   = err_q || (!s_tlast && beats_q == BW'(MAX_PKT_BEATS - 1));
                state_d = s_tlast ? ADVANCE : PASS;
            end
            ADVANCE: begin
                wr_ptr_d     = wrap ? base_q : next_ptr[ADDR_WIDTH-1:0];
                pkt_count_d  = pkt_count_q + 1'b1;
                last_bytes_d = bytes_q;
                beats_d      = '0;
                bytes_d      = '0;
                state_d      = cfg_enable ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            size_q       <= '0;
            wr_ptr_q     <= '0;
            bytes_q      <= '0;
            beats_q      <= '0;
            last_bytes_q <= '0;
            pkt_count_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            size_q       <= size_d;
            wr_ptr_q     <= wr_ptr_d;
            bytes_q      <= bytes_d;
            beats_q      <= beats_d;
            last_bytes_q <= last_bytes_d;
            pkt_count_q  <= pkt_count_d;
            err_q        <= err_d;
        end
    end
endmodule
